pc_redirect_ctrl: RTL and testbench
===================================

// Module: pc_redirect_ctrl
// PURPOSE
//  Sequencer in front of the pc unit: arbitrates PC-redirect sources (trap, EX branch, ID jump),
//  merges hazard stalls, and runs the halt/drain/resume FSM. Drives pc's new_pc_i/change_pc_i/
//  stall_i/halt_i and emits IF/ID flushes, so pc needs no knowledge of who redirected it.
// PARAMETERS
//  TRAP_VECTOR   32'h0000_0100  fixed target for exc_req_i
//  DRAIN_CYCLES  4              stall cycles spent draining pipeline before halt (1..15)
// PORTS
//  clk              in   1   clock, rising edge
//  rst_n            in   1   asynchronous reset, active low
//  exc_req_i        in   1   trap request (highest priority)
//  ex_br_req_i      in   1   taken branch resolved in EX
//  ex_br_target_i   in   32  EX branch target
//  id_jmp_req_i     in   1   direct jump decoded in ID
//  id_jmp_target_i  in   32  ID jump target
//  load_use_stall_i in   1   ID load-use hazard stall
//  mem_stall_i      in   1   data-memory wait stall
//  halt_req_i       in   1   halt request (level or pulse, sampled in RUN)
//  resume_i         in   1   leave HALTED
//  new_pc_o         out  32  redirect target -> pc.new_pc_i
//  change_pc_o      out  1   redirect strobe -> pc.change_pc_i
//  stall_o          out  1   -> pc.stall_i
//  halt_o           out  1   -> pc.halt_i
//  flush_if_o       out  1   kill instruction in IF/ID register
//  flush_id_o       out  1   kill instruction in ID/EX register
//  halted_o         out  1   FSM in HALTED
// BEHAVIOUR
//  Reset: state=RUN, drain counter=0; all 1-bit outputs 0, new_pc_o=0.
//  FSM RUN -> DRAIN (halt_req_i, no exc_req_i same cycle) -> HALTED (counter==DRAIN_CYCLES-1)
//      -> RUN (resume_i). rst_n low in any state -> RUN immediately.
//  RUN, combinational, zero latency (pc samples on the same edge):
//   - priority exc_req_i > ex_br_req_i > id_jmp_req_i; winner drives new_pc_o
//     (TRAP_VECTOR / ex_br_target_i / id_jmp_target_i), change_pc_o=1.
//   - exc or EX branch: flush_if_o=1, flush_id_o=1. ID jump: flush_if_o=1 only.
//   - no request: change_pc_o=0, new_pc_o=0, flushes 0.
//   - stall_o = load_use_stall_i | mem_stall_i, forced 0 when change_pc_o=1 (redirect beats stall);
//     exception: mem_stall_i with exc_req_i keeps stall_o=1 and suppresses the redirect until
//     mem_stall_i drops (trap must not abandon an in-flight memory access).
//   - exc_req_i and halt_req_i same cycle: trap taken, halt ignored that cycle.
//  DRAIN: stall_o=1, change_pc_o=0, all redirects ignored, flushes 0; 4-bit counter increments
//   each cycle from 0; halt_o asserted on final DRAIN cycle so pc stops fetch on entry to HALTED.
//  HALTED: halt_o=1, halted_o=1, stall_o=0, change_pc_o=0; pc restarts at 0 after resume
//   (pc's own halt semantics); resume_i has no effect outside HALTED; halt_req_i ignored here.
//  Outputs in DRAIN/HALTED are registered state decodes; RUN outputs combinational.
// CONFIGURATION
//  PC_CTRL_STATS_EN defined: adds out [31:0] redir_cnt_o, counts cycles with change_pc_o=1,
//   saturates at 32'hFFFF_FFFF, reset 0, not cleared by halt/resume.
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1 Reset released, no requests -> change_pc_o=0, stall_o=0, halt_o=0 for 10 cycles.
//  2 exc+ex_br(0x40)+id_jmp(0x80) same cycle -> new_pc_o=0x100, change_pc_o=1, flush_if/id=1.
//  3 id_jmp 0x80 with load_use_stall_i=1 -> change_pc_o=1, stall_o=0, flush_if_o=1, flush_id_o=0.
//  4 exc_req_i with mem_stall_i=1 for 3 cycles -> change_pc_o=0, stall_o=1; then 0x100 redirect.
//  5 halt_req_i pulse, DRAIN_CYCLES=4 -> stall_o=1 4 cycles, ex_br ignored, halted_o on cycle 5;
//    resume_i -> RUN next cycle, halt_o=0.
//  6 rst_n low mid-DRAIN -> all outputs 0 asynchronously; STATS_EN: 3 redirects -> redir_cnt_o=3.

Source files
------------

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: arbitrates pc redirect sources, merges stalls and runs the halt/drain/resume FSM.
// Optional: define PC_CTRL_STATS_EN to add redir_cnt_o, a saturating count of redirect cycles.
module pc_redirect_ctrl #(
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exc_req_i,
    input  logic        ex_br_req_i,
    input  logic [31:0] ex_br_target_i,
    input  logic        id_jmp_req_i,
    input  logic [31:0] id_jmp_target_i,
    input  logic        load_use_stall_i,
    input  logic        mem_stall_i,
    input  logic        halt_req_i,
    input  logic        resume_i,
    output logic [31:0] new_pc_o,
    output logic        change_pc_o,
    output logic        stall_o,
    output logic        halt_o,
    output logic        flush_if_o,
    output logic        flush_id_o,
`ifdef PC_CTRL_STATS_EN
    output logic [31:0] redir_cnt_o,
`endif
    output logic        halted_o
);
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
    localparam logic [3:0] LAST = 4'(DRAIN_CYCLES - 1);
    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       run, last, take_exc, take_br, take_jmp;
    // state and drain counter; reset also gates RUN outputs so everything drops at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end
    // redirect arbitration, stall merge, next state; a trap stuck behind a memory stall waits
    always_comb begin
        run         = (state == RUN) & rst_n;
        last        = cnt == LAST;
        take_exc    = run & exc_req_i & ~mem_stall_i;
        take_br     = run & ~exc_req_i & ex_br_req_i;
        take_jmp    = run & ~exc_req_i & ~ex_br_req_i & id_jmp_req_i;
        change_pc_o = take_exc | take_br | take_jmp;
        new_pc_o    = take_exc ? TRAP_VECTOR : take_br ? ex_br_target_i : take_jmp ? id_jmp_target_i : '0;
        flush_if_o  = change_pc_o;
        flush_id_o  = take_exc | take_br;
        stall_o     = (state == DRAIN) | (run & ~change_pc_o & (load_use_stall_i | mem_stall_i));
        halt_o      = (state == HALTED) | ((state == DRAIN) & last);
        halted_o    = state == HALTED;
        state_nxt   = (state == RUN)   ? ((halt_req_i & ~exc_req_i) ? DRAIN : RUN) :
                      (state == DRAIN) ? (last ? HALTED : DRAIN) :
                      (resume_i ? RUN : HALTED);
        cnt_nxt     = ((state == DRAIN) & ~last) ? cnt + 4'd1 : '0;
    end
`ifdef PC_CTRL_STATS_EN
    // saturating count of redirect cycles, only cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) redir_cnt_o <= '0;
        else if (change_pc_o && redir_cnt_o != '1) redir_cnt_o <= redir_cnt_o + 32'd1;
    end
`endif
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: directed and random stimulus checked against a behavioural model of pc_redirect_ctrl.
module tb_pc_redirect_ctrl;
    localparam logic [31:0] TRAP  = 32'h0000_0100;
    localparam int          DRAIN = 4;
    logic        clk = 0, rst_n = 0;
    logic        exc_req = 0, ex_br_req = 0, id_jmp_req = 0, load_use = 0, mem_stall = 0;
    logic        halt_req = 0, resume = 0;
    logic [31:0] ex_br_target = 0, id_jmp_target = 0;
    logic [31:0] new_pc;
    logic        change_pc, stall, halt, flush_if, flush_id, halted;
`ifdef PC_CTRL_STATS_EN
    logic [31:0] redir_cnt;
`endif
    int total = 0, bad = 0;
    int mode = 0, dcnt = 0;
    longint redirs = 0;
    logic [31:0] e_pc;
    logic        e_chg, e_st, e_halt, e_fif, e_fid, e_hd;

    pc_redirect_ctrl #(.TRAP_VECTOR(TRAP), .DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .rst_n(rst_n), .exc_req_i(exc_req), .ex_br_req_i(ex_br_req),
        .ex_br_target_i(ex_br_target), .id_jmp_req_i(id_jmp_req), .id_jmp_target_i(id_jmp_target),
        .load_use_stall_i(load_use), .mem_stall_i(mem_stall), .halt_req_i(halt_req),
        .resume_i(resume), .new_pc_o(new_pc), .change_pc_o(change_pc), .stall_o(stall),
        .halt_o(halt), .flush_if_o(flush_if), .flush_id_o(flush_id),
`ifdef PC_CTRL_STATS_EN
        .redir_cnt_o(redir_cnt),
`endif
        .halted_o(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // mode 0 = running, 1 = draining (dcnt cycles spent so far), 2 = halted
    task automatic model_outputs;
        {e_pc, e_chg, e_st, e_halt, e_fif, e_fid, e_hd} = '0;
        if (rst_n) begin
            if (mode == 0) begin
                if (exc_req && !mem_stall) begin e_pc = TRAP; e_chg = 1; e_fif = 1; e_fid = 1; end
                else if (!exc_req && ex_br_req) begin e_pc = ex_br_target; e_chg = 1; e_fif = 1; e_fid = 1; end
                else if (!exc_req && id_jmp_req) begin e_pc = id_jmp_target; e_chg = 1; e_fif = 1; end
                e_st = !e_chg && (load_use || mem_stall);
            end else if (mode == 1) begin
                e_st = 1;
                e_halt = (dcnt == DRAIN - 1);
            end else begin
                e_halt = 1;
                e_hd = 1;
            end
        end
    endtask

    task automatic step;
        #2;
        model_outputs();
        check("new_pc", new_pc, e_pc);
        check("change_pc", 32'(change_pc), 32'(e_chg));
        check("stall", 32'(stall), 32'(e_st));
        check("halt", 32'(halt), 32'(e_halt));
        check("flush_if", 32'(flush_if), 32'(e_fif));
        check("flush_id", 32'(flush_id), 32'(e_fid));
        check("halted", 32'(halted), 32'(e_hd));
`ifdef PC_CTRL_STATS_EN
        check("redir_cnt", redir_cnt, 32'(redirs));
`endif
        @(posedge clk);
        if (!rst_n) begin
            mode = 0; dcnt = 0; redirs = 0;
        end else begin
            if (e_chg && redirs < 64'hFFFF_FFFF) redirs++;
            if (mode == 0 && halt_req && !exc_req) begin mode = 1; dcnt = 0; end
            else if (mode == 1) begin dcnt++; if (dcnt == DRAIN) mode = 2; end
            else if (mode == 2 && resume) mode = 0;
        end
        #1;
    endtask

    task automatic idle;
        {exc_req, ex_br_req, id_jmp_req, load_use, mem_stall, halt_req, resume} = '0;
    endtask

    initial begin
        ex_br_target = 32'h40;
        id_jmp_target = 32'h80;
        step();
        rst_n = 1;
        repeat (10) step();
        exc_req = 1; ex_br_req = 1; id_jmp_req = 1; step(); idle();
        id_jmp_req = 1; load_use = 1; step(); idle();
        exc_req = 1; mem_stall = 1; repeat (3) step();
        mem_stall = 0; step(); idle();
        halt_req = 1; step(); idle();
        ex_br_req = 1; repeat (4) step(); idle();
        step();
        resume = 1; step(); idle();
        repeat (2) step();
        exc_req = 1; halt_req = 1; step(); idle();
        ex_br_req = 1; step();
        id_jmp_req = 1; ex_br_req = 0; step();
        exc_req = 1; step(); idle();
        halt_req = 1; step(); idle();
        step();
        rst_n = 0; step();
        rst_n = 1; step();
        for (int i = 0; i < 600; i++) begin
            exc_req       = $urandom_range(0, 9) == 0;
            ex_br_req     = $urandom_range(0, 4) == 0;
            id_jmp_req    = $urandom_range(0, 4) == 0;
            load_use      = $urandom_range(0, 4) == 0;
            mem_stall     = $urandom_range(0, 4) == 0;
            halt_req      = $urandom_range(0, 19) == 0;
            resume        = $urandom_range(0, 3) == 0;
            rst_n         = $urandom_range(0, 99) != 0;
            ex_br_target  = $urandom;
            id_jmp_target = $urandom;
            step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
